sdram_aref: RTL

SDRAM_AREF -- requirements
Module: sdram_aref

---
 rtl/sdram_aref.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sdram_aref.sv
// rtl/sdram_aref.sv - SDRAM auto-refresh request and command sequencer
//
// Requests a refresh every REF_PERIOD cycles once SDRAM init is complete.
// When the arbiter grants, it issues PRE (all banks), waits T_RP, issues
// AREF, waits T_RFC and then pulses flag_aref_end.
//
// Ports:
//   sclk          - clock, rising edge
//   s_rst         - synchronous active-high reset
//   flag_init_end - SDRAM power-up init complete (level)
//   aref_en       - arbiter grant, honoured only while aref_req is high
//   aref_req      - refresh request to the arbiter
//   aref_cmd      - registered {cs_n,ras_n,cas_n,we_n}
//   aref_addr     - registered address (A10 set during PRE)
//   flag_aref_end - one-cycle pulse in the final cycle of a sequence
//   ref_miss      - one-cycle pulse when an interval elapses unserved
module sdram_aref #(
  parameter int REF_PERIOD = 750,
  parameter int T_RP       = 2,
  parameter int T_RFC      = 7
) (
  input  logic        sclk,
  input  logic        s_rst,
  input  logic        flag_init_end,
  input  logic        aref_en,
  output logic        aref_req,
  output logic [3:0]  aref_cmd,
  output logic [11:0] aref_addr,
  output logic        flag_aref_end,
  output logic        ref_miss
);

  localparam int CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRE      = 3'd1;
  localparam logic [2:0] ST_WAIT_RP  = 3'd2;
  localparam logic [2:0] ST_AREF     = 3'd3;
  localparam logic [2:0] ST_WAIT_RFC = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic [2:0]    state_q, state_d;
  logic [15:0]   wait_q, wait_d;
  logic [3:0]    cmd_q, cmd_d;
  logic [11:0]   addr_q, addr_d;
  logic          fend_q, fend_d;
  logic          miss_q, miss_d;
  logic          tick;
  logic          grant;

  assign tick  = flag_init_end && (cnt_q == CW'(REF_PERIOD - 1));
  assign grant = aref_req && aref_en;

  // Interval counter and pending request. A tick outranks the grant's
  // clear so a request born in the grant cycle is not lost.
  always_comb begin
    cnt_d     = cnt_q;
    pending_d = pending_q;
    miss_d    = 1'b0;
    if (!flag_init_end) begin
      cnt_d     = '0;
      pending_d = 1'b0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      if (tick) begin
        pending_d = 1'b1;
        // A grant in the tick cycle consumes the old request, so only an
        // unserved one counts as missed.
        miss_d    = pending_q && !grant;
      end else if (grant) begin
        pending_d = 1'b0;
      end
    end
  end

  // Sequencer. wait_q counts cycles spent in the two wait states; a wait
  // state is skipped entirely when its spacing is a single cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_PRE;
      end
      ST_PRE: begin
        wait_d  = '0;
        state_d = (T_RP > 1) ? ST_WAIT_RP : ST_AREF;
      end
      ST_WAIT_RP: begin
        if (wait_q == 16'(T_RP - 2)) state_d = ST_AREF;
        else                         wait_d  = wait_q + 16'd1;
      end
      ST_AREF: begin
        wait_d  = '0;
        state_d = (T_RFC > 1) ? ST_WAIT_RFC : ST_DONE;
      end
      ST_WAIT_RFC: begin
        if (wait_q == 16'(T_RFC - 2)) state_d = ST_DONE;
        else                          wait_d  = wait_q + 16'd1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state
  // register in the cycle the state is occupied.
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = 12'h000;
    fend_d = 1'b0;
    case (state_d)
      ST_PRE: begin
        cmd_d  = CMD_PRE;
        addr_d = 12'h400;
      end
      ST_AREF: cmd_d  = CMD_AREF;
      ST_DONE: fend_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      cmd_q     <= CMD_NOP;
      addr_q    <= 12'h000;
      fend_q    <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      state_q   <= state_d;
      wait_q    <= wait_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      fend_q    <= fend_d;
      miss_q    <= miss_d;
    end
  end

  assign aref_req      = pending_q && (state_q == ST_IDLE);
  assign aref_cmd      = cmd_q;
  assign aref_addr     = addr_q;
  assign flag_aref_end = fend_q;
  assign ref_miss      = miss_q;

endmodule
